// File: rtl/hsyncfifo_param.sv
// hsyncfifo_param: single-clock FIFO with registered status flags, sticky
// overflow/underflow, synchronous clear and optional first-word-fall-through.
//
// Parameters
//   DATA_W    data width (1..64)
//   DEPTH     storage words, power of 2 (4..65536)
//   AFULL_TH  almost-full threshold: afull_flag = (count >= AFULL_TH)
//   AEMPTY_TH almost-empty threshold: aempty_flag = (count <= AEMPTY_TH)
//   FWFT      0 = standard read (data one edge after read), 1 = fall-through
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear (priority over we/re)
//   we, di              write request and data
//   re                  read request
//   dout                read data ("do" is a reserved word in SystemVerilog)
//   empty_flag          no readable word
//   full_flag           DEPTH words held
//   afull_flag          count >= AFULL_TH
//   aempty_flag         count <= AEMPTY_TH
//   count               words held (FWFT: includes the word shown on dout)
//   overflow, underflow sticky error flags, cleared by clr or reset
//
// Handshake: a write is accepted on an edge where we=1 and full_flag=0; a
// read is accepted on an edge where re=1 and empty_flag=0. Requests made
// while full/empty are dropped and recorded in the sticky flags. No
// operation is accepted until the internal reset synchroniser has released.
module hsyncfifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2048,
  parameter int AFULL_TH  = 1920,
  parameter int AEMPTY_TH = 6,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       we,
  input  logic [DATA_W-1:0]          di,
  input  logic                       re,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty_flag,
  output logic                       full_flag,
  output logic                       afull_flag,
  output logic                       aempty_flag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  // Words held in the RAM only; equals count in standard mode, and
  // count minus the prefetched word in FWFT mode.
  logic [CW-1:0] mem_cnt;
  logic          out_valid;

  logic [1:0]    rst_sync;
  logic          run;

  logic          wr_acc;
  logic          rd_acc;
  logic          pop;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] mem_cnt_nxt;
  logic          out_valid_nxt;
  logic          empty_nxt;

  // Reset release is re-timed through two flops so no operation lands on
  // the first edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  always_comb begin
    wr_acc = run && we && !full_flag && !clr;
    rd_acc = run && re && !empty_flag && !clr;
    // pop = a RAM read into dout. In FWFT mode the output register is
    // refilled whenever it is empty or being consumed this edge.
    if (FWFT != 0) begin
      pop = run && !clr && (mem_cnt != '0) && (!out_valid || rd_acc);
    end else begin
      pop = rd_acc;
    end
    count_nxt   = count + CW'(wr_acc) - CW'(rd_acc);
    mem_cnt_nxt = mem_cnt + CW'(wr_acc) - CW'(pop);
    if (FWFT != 0) begin
      if (pop) begin
        out_valid_nxt = 1'b1;
      end else if (rd_acc) begin
        out_valid_nxt = 1'b0;
      end else begin
        out_valid_nxt = out_valid;
      end
      empty_nxt = !out_valid_nxt;
    end else begin
      out_valid_nxt = 1'b0;
      empty_nxt     = (count_nxt == '0);
    end
  end

  // Storage array: one write port, no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= di;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_cnt     <= '0;
      out_valid   <= 1'b0;
      dout        <= '0;
      empty_flag  <= 1'b1;
      full_flag   <= 1'b0;
      afull_flag  <= (AFULL_TH == 0);
      aempty_flag <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (run && clr) begin
      // dout keeps its last value; in FWFT mode it is simply marked invalid.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_cnt     <= '0;
      out_valid   <= 1'b0;
      empty_flag  <= 1'b1;
      full_flag   <= 1'b0;
      afull_flag  <= (AFULL_TH == 0);
      aempty_flag <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      count       <= count_nxt;
      mem_cnt     <= mem_cnt_nxt;
      out_valid   <= out_valid_nxt;
      empty_flag  <= empty_nxt;
      full_flag   <= (count_nxt == CW'(DEPTH));
      afull_flag  <= (count_nxt >= CW'(AFULL_TH));
      aempty_flag <= (count_nxt <= CW'(AEMPTY_TH));
      if (run && we && full_flag) begin
        overflow <= 1'b1;
      end
      if (run && re && empty_flag) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/hsyncfifo_param.md
HSYNCFIFO_PARAM -- requirements
Module: hsyncfifo_param

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, data width in bits (1..64).
REQ-002 The block SHALL expose parameter DEPTH, default 2048, storage words; must be a power of 2, 4..65536.
REQ-003 The block SHALL expose parameter AFULL_TH, default 1920, almost-full threshold in words (1..DEPTH).
REQ-004 The block SHALL expose parameter AEMPTY_TH, default 6, almost-empty threshold in words (0..DEPTH-1).
REQ-005 The block SHALL expose parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-006 The block SHALL have these ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear.
- we  in  1  write request.
- di  in  DATA_W  write data.
- re  in  1  read request.
- do  out  DATA_W  read data.
- empty_flag  out  1  no readable word.
- full_flag  out  1  DEPTH words held.
- afull_flag  out  1  count >= AFULL_TH.
- aempty_flag  out  1  count <= AEMPTY_TH.
- count  out  CW=$clog2(DEPTH)+1  words held.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 A write SHALL be accepted iff we=1 and full_flag=0; di is stored at the write pointer on that edge.
REQ-008 A read SHALL be accepted iff re=1 and empty_flag=0.
REQ-009 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without gap.
REQ-010 count SHALL update on the edge: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-011 A simultaneous write and read SHALL both be accepted when 0 < count < DEPTH. When full, only the read is accepted. When empty, only the write is accepted.
REQ-012 All flags SHALL be registered and consistent with count in the same cycle, with no combinational path from we/re to any output.
REQ-013 Flag definitions: empty_flag = (count==0); full_flag = (count==DEPTH); afull_flag = (count>=AFULL_TH); aempty_flag = (count<=AEMPTY_TH).
REQ-014 Standard mode (FWFT=0): do SHALL present the read word on the edge after an accepted read, and SHALL hold its value otherwise.
REQ-015 Standard mode: empty_flag SHALL deassert on the first edge after a write into an empty FIFO.
REQ-016 FWFT mode (FWFT=1): the head word SHALL be prefetched into an output register, and do SHALL be valid whenever empty_flag=0.
REQ-017 FWFT mode: an accepted read pops the word on do, and do shows the next word after that edge.
REQ-018 FWFT mode: count SHALL include the prefetched word. empty_flag deasserts 2 edges after a write into an empty FIFO; count increments 1 edge after the write.
REQ-019 we=1 with full_flag=1 SHALL drop the data and set overflow; re=1 with empty_flag=1 SHALL set underflow. Both flags stay set until clr or reset.
REQ-020 clr=1 SHALL, on the edge, have priority over we/re and:
- zero the pointers, count, overflow and underflow;
- set empty_flag=1 and aempty_flag=1;
- leave memory contents and do unchanged (FWFT: do invalid).
REQ-021 Storage SHALL infer simple dual-port block RAM: one write port, one read port, no reset on the array.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously set:
- pointers=0, count=0, do=0;
- empty_flag=1, aempty_flag=1;
- full_flag=0, afull_flag=0 (afull_flag=1 only if AFULL_TH==0, which is illegal);
- overflow=0, underflow=0.
REQ-023 Reset deassertion SHALL be synchronised internally so the first accepted operation occurs no earlier than the 2nd rising edge after rst_n rises.
REQ-024 Reset mid-operation SHALL discard all held words; the first read after reset returns the first word written after reset.

Verification
Parameters for all scenarios: DATA_W=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2.
REQ-025 Fill/drain (FWFT=0): write 0x00..0x0F, then read 16 times.
- afull_flag rises on the edge count becomes 12; full_flag rises at 16.
- do reads 0x00..0x0F in order.
- empty_flag rises after the 16th read; aempty_flag rises when count becomes 2.
REQ-026 Overflow/underflow: write 17 words.
- 17th word is dropped; overflow=1; count=16.
- Drain, then re=1 once more: underflow=1, count=0, do holds 0x0F.
- clr=1: both sticky flags clear.
REQ-027 Wrap and concurrency: write 10 words, then 40 cycles of we=re=1 with incrementing data.
- count stays 10 throughout.
- Output order is exact across 3 pointer wraps.
REQ-028 FWFT=1:
- Write 0xA5 to an empty FIFO: empty_flag=0 and do=0xA5 on the 2nd edge.
- re=1: empty_flag=1 next edge, count=0.
REQ-029 Reset mid-operation: with count=9, pulse rst_n low between edges.
- Outputs go to reset values immediately.
- Then write 0x3C and read: do=0x3C.
